lcd_capture: RTL
================

# lcd_capture

Captures the gameboy core's LCD pixel stream (2-bit shade, pixel strobe, hsync, vsync) into a 160x144 framebuffer and exposes a random-access read port for the downstream HDMI/VGA scan-out logic. It sits directly downstream of the `gameboy` instance in the board top and upstream of the display timing generator. Everything runs on the single core clock domain.

## Interface
- `LCD_W`, 160: pixels per line.
- `LCD_H`, 144: lines per frame.
- `clock`  in  1  core clock (33.3 MHz).
- `reset`  in  1  reset, synchronous, active-high.
- `pixel_data`  in  2  shade of the current pixel.
- `pixel_clock`  in  1  rising edge means `pixel_data` is valid for one pixel.
- `hsync`  in  1  rising edge means end of line.
- `vsync`  in  1  rising edge means end of frame / start of next.
- `rd_en`  in  1  read request.
- `rd_x`  in  8  read column.
- `rd_y`  in  8  read row.
- `rd_data`  out  2  read shade.
- `rd_valid`  out  1  `rd_data` is valid.
- `frame_done`  out  1  one-cycle pulse when a complete frame is captured.
- `frame_count`  out  8  number of completed frames; wraps 255→0.
- `err_overflow`  out  1  sticky; set on any dropped out-of-range pixel.

## Operation
- Input stage: `pixel_clock`, `hsync` and `vsync` are registered once. The previous-sample registers reset to 1, so no spurious edge occurs on reset release. `pixel_data` is registered alongside, keeping it aligned with the strobe.
- FSM has two states:
  - WAIT_VSYNC (reset state): all strobes are ignored. A vsync rising edge moves to ACTIVE with x=0, y=0, row_base=0.
  - ACTIVE:
    - Pixel edge: if x<LCD_W and y<LCD_H, write to address row_base+x, then x+=1. Otherwise drop the pixel, set `err_overflow`, and leave x unchanged.
    - hsync edge: x=0. If y<LCD_H, then y+=1 and row_base+=LCD_W. row_base is maintained incrementally; no multiplier.
    - vsync edge: pulse `frame_done`, increment `frame_count`, set x=y=row_base=0, and stay in ACTIVE.
- Simultaneous events in one cycle: the pixel is written at the current coordinate first, then the hsync/vsync update is applied. If hsync and vsync coincide, vsync wins.
- Read port:
  - Address = (rd_y<<7)+(rd_y<<5)+rd_x, registered.
  - RAM is read-first; a read and write to the same address in the same cycle returns the old data.
  - Out-of-range reads (rd_x≥LCD_W or rd_y≥LCD_H) return 2'b00 and still assert `rd_valid`.
- Reset mid-operation:
  - x, y, row_base and `frame_count` clear to 0; `err_overflow` clears; the FSM returns to WAIT_VSYNC.
  - RAM contents are not cleared.
- Reset values of outputs: `rd_data`=0, `rd_valid`=0, `frame_done`=0, `frame_count`=0, `err_overflow`=0.

## Timing
- Write: the RAM write occurs 2 cycles after `pixel_clock` rises at the port (input register, then edge detect/write).
- hsync/vsync edges are detected 1 cycle after the input register. `frame_done` is asserted 2 cycles after `vsync` rises.
- Read: `rd_valid`/`rd_data` are returned 2 cycles after `rd_en` (address register, RAM register). The port is fully pipelined: one read per cycle, no stall.
- Minimum pixel strobe spacing is 2 cycles (high one cycle, low one cycle).

## Configuration
- `LCD_CAPTURE_DOUBLE_BUFFER_EN`:
  - Defined: two banks. A 1-bit `wr_bank` resets to 0 and toggles on every `frame_done`. The read bank is always `!wr_bank`, so scan-out sees only completed frames (no tearing). Reads before the first completed frame return RAM power-up contents.
  - Undefined: a single bank shared by writer and reader. Tearing is allowed.

## Structure
- Package `gb_video_pkg`: `LCD_W`, `LCD_H`, `FB_ADDR_W`=15 (16 when double-buffered), and a 2-bit shade typedef.
- Sub-module `fb_ram`: simple dual-port (1W/1R) read-first synchronous RAM, 2 bits wide, inferred as block RAM.

## Test plan
- Reset, vsync pulse, 160 strobes with data=x[1:0], then hsync. Read (5,0) → `rd_data`=2'b01 exactly 2 cycles after `rd_en`.
- 161 strobes on line 0 → `err_overflow`=1. Read (0,1) returns its prior value (2'b00 after an earlier zero fill).
- A full 144-line frame followed by vsync → `frame_done` high for exactly 1 cycle, `frame_count`=1.
- Assert reset mid-line, then send 10 strobes before any vsync → no RAM writes; capture begins only after the next vsync.
- Read (160,0) and (0,144) → 2'b00 with `rd_valid`=1.
- With `LCD_CAPTURE_DOUBLE_BUFFER_EN`: frame 1 all 2'b11, frame 2 partially written with 2'b00 → reads return 2'b11 until the second vsync, then 2'b00.

Source files
------------

// File: rtl/gb_video_pkg.sv
// Shared LCD geometry and framebuffer sizing for the gameboy video path.
// LCD_CAPTURE_DOUBLE_BUFFER_EN widens the framebuffer address by one bank bit.
package gb_video_pkg;

   localparam int unsigned LCD_W    = 160;
   localparam int unsigned LCD_H    = 144;
   localparam int unsigned FB_PIX_W = 15;
`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
   localparam int unsigned FB_ADDR_W = FB_PIX_W + 1;
`else
   localparam int unsigned FB_ADDR_W = FB_PIX_W;
`endif

   typedef logic [1:0] shade_t;

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port (1W/1R) read-first synchronous RAM holding 2-bit shades.
import gb_video_pkg::*;

module fb_ram #(
   parameter int unsigned ADDR_W = FB_ADDR_W
) (
   input  logic              clock,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  shade_t            i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output shade_t            o_rd_data
);

   shade_t r_mem [0:(1 << ADDR_W)-1];
   shade_t r_rd_data;

   // Read and write in one block: a same-address collision returns the old word.
   always_ff @(posedge clock) begin
      if (i_wr_en)
         r_mem[i_wr_addr] <= i_wr_data;
      r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/lcd_capture.sv
// Captures the LCD pixel stream into a 160x144 framebuffer with a pipelined read port.
// Optional LCD_CAPTURE_DOUBLE_BUFFER_EN: two banks, scan-out reads the last completed frame.
import gb_video_pkg::*;

module lcd_capture (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] pixel_data,
   input  logic       pixel_clock,
   input  logic       hsync,
   input  logic       vsync,
   input  logic       rd_en,
   input  logic [7:0] rd_x,
   input  logic [7:0] rd_y,
   output logic [1:0] rd_data,
   output logic       rd_valid,
   output logic       frame_done,
   output logic [7:0] frame_count,
   output logic       err_overflow
);

   localparam logic [0:0] S_WAIT_VSYNC = 1'b0;
   localparam logic [0:0] S_ACTIVE     = 1'b1;

   localparam logic [7:0]          W8       = 8'(LCD_W);
   localparam logic [7:0]          H8       = 8'(LCD_H);
   localparam logic [FB_PIX_W-1:0] ROW_STEP = FB_PIX_W'(LCD_W);

   logic   r_pclk, r_pclk_d, r_hsync, r_hsync_d, r_vsync, r_vsync_d;
   shade_t r_pdata;
   logic   w_pix_edge, w_hs_edge, w_vs_edge;

   logic [0:0]          r_state;
   logic [7:0]          r_x, r_y;
   logic [FB_PIX_W-1:0] r_row_base;
   logic                r_frame_done, r_err;
   logic [7:0]          r_frame_count;
   logic                w_in_range, w_wr_en;
   logic [FB_PIX_W-1:0] w_pix_addr;

   logic                 r_rd_en1, r_rd_oor1, r_rd_valid, r_rd_oor2;
   logic [FB_PIX_W-1:0]  r_rd_addr;
   logic [FB_PIX_W-1:0]  w_rd_lin;
   logic                 w_rd_oor;
   logic [FB_ADDR_W-1:0] w_wr_addr, w_rd_addr;
   shade_t               w_ram_q;

`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
   logic r_wr_bank;
`endif

   // Delayed samples reset high so a level already high at release is not an edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pclk    <= 1'b1;
         r_pclk_d  <= 1'b1;
         r_hsync   <= 1'b1;
         r_hsync_d <= 1'b1;
         r_vsync   <= 1'b1;
         r_vsync_d <= 1'b1;
         r_pdata   <= '0;
      end else begin
         r_pclk    <= pixel_clock;
         r_pclk_d  <= r_pclk;
         r_hsync   <= hsync;
         r_hsync_d <= r_hsync;
         r_vsync   <= vsync;
         r_vsync_d <= r_vsync;
         r_pdata   <= pixel_data;
      end
   end

   assign w_pix_edge = r_pclk  & ~r_pclk_d;
   assign w_hs_edge  = r_hsync & ~r_hsync_d;
   assign w_vs_edge  = r_vsync & ~r_vsync_d;

   assign w_in_range = (r_x < W8) && (r_y < H8);
   assign w_wr_en    = (r_state == S_ACTIVE) && w_pix_edge && w_in_range;
   assign w_pix_addr = r_row_base + FB_PIX_W'(r_x);

   // Pixel uses the current coordinate; the sync update below then overrides x/y.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= S_WAIT_VSYNC;
         r_x           <= '0;
         r_y           <= '0;
         r_row_base    <= '0;
         r_frame_done  <= 1'b0;
         r_frame_count <= '0;
         r_err         <= 1'b0;
`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
         r_wr_bank     <= 1'b0;
`endif
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            S_WAIT_VSYNC: begin
               if (w_vs_edge) begin
                  r_state    <= S_ACTIVE;
                  r_x        <= '0;
                  r_y        <= '0;
                  r_row_base <= '0;
               end
            end
            S_ACTIVE: begin
               if (w_pix_edge) begin
                  if (w_in_range)
                     r_x <= r_x + 8'd1;
                  else
                     r_err <= 1'b1;
               end
               if (w_vs_edge) begin
                  r_frame_done  <= 1'b1;
                  r_frame_count <= r_frame_count + 8'd1;
                  r_x           <= '0;
                  r_y           <= '0;
                  r_row_base    <= '0;
`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
                  r_wr_bank     <= ~r_wr_bank;
`endif
               end else if (w_hs_edge) begin
                  r_x <= '0;
                  if (r_y < H8) begin
                     r_y        <= r_y + 8'd1;
                     r_row_base <= r_row_base + ROW_STEP;
                  end
               end
            end
            default: r_state <= S_WAIT_VSYNC;
         endcase
      end
   end

   assign w_rd_lin = (FB_PIX_W'(rd_y) << 7) + (FB_PIX_W'(rd_y) << 5) + FB_PIX_W'(rd_x);
   assign w_rd_oor = (rd_x >= W8) || (rd_y >= H8);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rd_en1   <= 1'b0;
         r_rd_oor1  <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_oor2  <= 1'b0;
      end else begin
         r_rd_en1   <= rd_en;
         r_rd_oor1  <= w_rd_oor;
         r_rd_valid <= r_rd_en1;
         r_rd_oor2  <= r_rd_oor1;
      end
   end

   always_ff @(posedge clock) begin
      r_rd_addr <= w_rd_lin;
   end

`ifdef LCD_CAPTURE_DOUBLE_BUFFER_EN
   assign w_wr_addr = {r_wr_bank, w_pix_addr};
   assign w_rd_addr = {~r_wr_bank, r_rd_addr};
`else
   assign w_wr_addr = w_pix_addr;
   assign w_rd_addr = r_rd_addr;
`endif

   fb_ram #(.ADDR_W(FB_ADDR_W)) u_fb_ram (
      .clock     (clock),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (w_wr_addr),
      .i_wr_data (r_pdata),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_ram_q)
   );

   assign rd_data      = (r_rd_valid && !r_rd_oor2) ? w_ram_q : 2'b00;
   assign rd_valid     = r_rd_valid;
   assign frame_done   = r_frame_done;
   assign frame_count  = r_frame_count;
   assign err_overflow = r_err;

endmodule
